// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the pipeline has fixed priority over a debug/loader port, and a
// starvation counter forces a one-cycle debug grant that stalls the pipeline.
module dmem_arbiter #(
  parameter int unsigned ADDR_W       = 11,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  // pipeline requester
  input  logic              pl_read,
  input  logic [3:0]        pl_writeb,
  input  logic [ADDR_W-1:0] pl_addr,
  input  logic [31:0]       pl_wdata,
  output logic              pl_stall,
  output logic              pl_rvalid,
  // debug requester
  input  logic              dbg_valid,
  input  logic [3:0]        dbg_writeb,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_ready,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata,
  // dmem side
  output logic              mem_read,
  output logic [3:0]        mem_writeb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT - 1);

  typedef enum logic {StPipe, StForce} state_e;

  state_e     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       resp_pl_q, resp_pl_d;
  logic       resp_dbg_q, resp_dbg_d;

  logic pl_req;
  logic dbg_rd;
  logic gnt_pl;
  logic dbg_refused;

  // Grant and memory mux
  always_comb begin
    pl_req     = pl_read | (|pl_writeb);
    dbg_rd     = dbg_valid && (dbg_writeb == 4'b0000);
    gnt_pl     = (state_q == StPipe) && pl_req;
    dbg_ready  = (state_q == StForce) || (!pl_req && dbg_valid);
    pl_stall   = (state_q == StForce) && pl_req;

    mem_read   = 1'b0;
    mem_writeb = 4'b0000;
    mem_addr   = pl_addr;
    mem_wdata  = pl_wdata;
    if (gnt_pl) begin
      mem_read   = pl_read;
      mem_writeb = pl_writeb;
    end else begin
      // Debug owns the port whenever the pipeline is not granted; strobes need dbg_valid.
      mem_read   = dbg_rd;
      mem_writeb = dbg_valid ? dbg_writeb : 4'b0000;
      mem_addr   = dbg_addr;
      mem_wdata  = dbg_wdata;
    end
  end

  // Starvation tracking and response tags
  always_comb begin
    dbg_refused = dbg_valid && !dbg_ready;
    state_d     = StPipe;
    starve_d    = 4'd0;
    if (dbg_refused) begin
      if (starve_q == StarveMax) begin
        state_d = StForce;
      end else begin
        starve_d = starve_q + 4'd1;
      end
    end
    resp_pl_d  = gnt_pl && pl_read;
    resp_dbg_d = !gnt_pl && dbg_rd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StPipe;
      starve_q   <= 4'd0;
      resp_pl_q  <= 1'b0;
      resp_dbg_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      resp_pl_q  <= resp_pl_d;
      resp_dbg_q <= resp_dbg_d;
    end
  end

  // A reset arriving while a tag is pending suppresses the response immediately.
  always_comb begin
    pl_rvalid  = resp_pl_q && !rst;
    dbg_rvalid = resp_dbg_q && !rst;
    dbg_rdata  = mem_rdata;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter (ADDR_W=11, STARVE_LIMIT=4).
module tb_dmem_arbiter;

  localparam int unsigned AW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          pl_read;
  logic [3:0]    pl_writeb;
  logic [AW-1:0] pl_addr;
  logic [31:0]   pl_wdata;
  logic          pl_stall;
  logic          pl_rvalid;
  logic          dbg_valid;
  logic [3:0]    dbg_writeb;
  logic [AW-1:0] dbg_addr;
  logic [31:0]   dbg_wdata;
  logic          dbg_ready;
  logic          dbg_rvalid;
  logic [31:0]   dbg_rdata;
  logic          mem_read;
  logic [3:0]    mem_writeb;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W      (AW),
    .STARVE_LIMIT(4)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .pl_read   (pl_read),
    .pl_writeb (pl_writeb),
    .pl_addr   (pl_addr),
    .pl_wdata  (pl_wdata),
    .pl_stall  (pl_stall),
    .pl_rvalid (pl_rvalid),
    .dbg_valid (dbg_valid),
    .dbg_writeb(dbg_writeb),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_ready (dbg_ready),
    .dbg_rvalid(dbg_rvalid),
    .dbg_rdata (dbg_rdata),
    .mem_read  (mem_read),
    .mem_writeb(mem_writeb),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    for (int i = 0; i < 2; i++) begin
      #4;
      checks++;
      if ({pl_stall, pl_rvalid, dbg_rvalid, dbg_ready, mem_read, mem_writeb} !== 9'd0) begin
        errors++;
        $display("FAIL reset_outputs cyc %0d got %b exp 0", i,
                 {pl_stall, pl_rvalid, dbg_rvalid, dbg_ready, mem_read, mem_writeb});
      end
      cyc();
    end
    rst = 1'b0;
    dbg_valid = 1'b1; dbg_writeb = 4'b0000; dbg_addr = 11'h123;
    #4;
    checks++;
    if ({dbg_ready, mem_read, mem_addr} !== {1'b1, 1'b1, 11'h123}) begin
      errors++;
      $display("FAIL idle_dbg_grant got rdy=%b rd=%b addr=%h exp 1 1 123",
               dbg_ready, mem_read, mem_addr);
    end
    cyc();
    dbg_valid = 1'b0; mem_rdata = 32'h1234_5678;
    #4;
    checks++;
    if ({dbg_rvalid, pl_rvalid, dbg_rdata} !== {2'b10, 32'h1234_5678}) begin
      errors++;
      $display("FAIL idle_dbg_rdata got dv=%b pv=%b d=%h exp 1 0 12345678",
               dbg_rvalid, pl_rvalid, dbg_rdata);
    end
    cyc();
  endtask

  task automatic test_pl_read();
    pl_read = 1'b1; pl_addr = 11'h010;
    #4;
    checks++;
    if ({mem_read, mem_addr, pl_stall, dbg_ready} !== {1'b1, 11'h010, 2'b00}) begin
      errors++;
      $display("FAIL pl_read_req got rd=%b addr=%h st=%b rdy=%b exp 1 010 0 0",
               mem_read, mem_addr, pl_stall, dbg_ready);
    end
    cyc();
    pl_read = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    #4;
    checks++;
    if ({pl_rvalid, dbg_rvalid} !== 2'b10) begin
      errors++;
      $display("FAIL pl_read_resp got pv=%b dv=%b exp 1 0", pl_rvalid, dbg_rvalid);
    end
    cyc();
    #4;
    checks++;
    if (pl_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL pl_read_single got pv=%b exp 0", pl_rvalid);
    end
    cyc();
  endtask

  task automatic test_starvation();
    pl_read = 1'b1; pl_addr = 11'h020;
    dbg_valid = 1'b1; dbg_writeb = 4'b0000; dbg_addr = 11'h055;
    for (int i = 0; i < 4; i++) begin
      #4;
      checks++;
      if ({dbg_ready, pl_stall, mem_addr} !== {2'b00, 11'h020}) begin
        errors++;
        $display("FAIL starve_refuse cyc %0d got rdy=%b st=%b addr=%h exp 0 0 020",
                 i, dbg_ready, pl_stall, mem_addr);
      end
      cyc();
    end
    #4;
    checks++;
    if ({dbg_ready, pl_stall, mem_read, mem_addr} !== {3'b111, 11'h055}) begin
      errors++;
      $display("FAIL starve_force got rdy=%b st=%b rd=%b addr=%h exp 1 1 1 055",
               dbg_ready, pl_stall, mem_read, mem_addr);
    end
    cyc();
    dbg_valid = 1'b0; mem_rdata = 32'hCAFE_F00D;
    #4;
    checks++;
    if ({pl_stall, dbg_rvalid, pl_rvalid, dbg_rdata} !== {3'b010, 32'hCAFE_F00D}) begin
      errors++;
      $display("FAIL starve_after got st=%b dv=%b pv=%b d=%h exp 0 1 0 cafef00d",
               pl_stall, dbg_rvalid, pl_rvalid, dbg_rdata);
    end
    cyc();
    pl_read = 1'b0;
    #4;
    checks++;
    if ({pl_rvalid, dbg_rvalid} !== 2'b10) begin
      errors++;
      $display("FAIL starve_pl_resume got pv=%b dv=%b exp 1 0", pl_rvalid, dbg_rvalid);
    end
    cyc();
  endtask

  task automatic test_force_write();
    pl_read = 1'b1; pl_addr = 11'h030;
    dbg_valid = 1'b1; dbg_writeb = 4'b0011; dbg_wdata = 32'h0000_ABCD; dbg_addr = 11'h066;
    for (int i = 0; i < 4; i++) cyc();
    #4;
    checks++;
    if ({mem_writeb, mem_wdata, mem_read, pl_stall, mem_addr} !==
        {4'b0011, 32'h0000_ABCD, 2'b01, 11'h066}) begin
      errors++;
      $display("FAIL force_write got wb=%b wd=%h rd=%b st=%b addr=%h exp 0011 0000abcd 0 1 066",
               mem_writeb, mem_wdata, mem_read, pl_stall, mem_addr);
    end
    cyc();
    dbg_valid = 1'b0; dbg_writeb = 4'b0000;
    #4;
    checks++;
    if ({pl_rvalid, dbg_rvalid, pl_stall, mem_read} !== 4'b0001) begin
      errors++;
      $display("FAIL force_write_next got pv=%b dv=%b st=%b rd=%b exp 0 0 0 1",
               pl_rvalid, dbg_rvalid, pl_stall, mem_read);
    end
    cyc();
    pl_read = 1'b0;
    #4;
    checks++;
    if ({pl_rvalid, dbg_rvalid} !== 2'b10) begin
      errors++;
      $display("FAIL force_write_load got pv=%b dv=%b exp 1 0", pl_rvalid, dbg_rvalid);
    end
    cyc();
  endtask

  task automatic test_withdraw();
    pl_read = 1'b1; pl_addr = 11'h040;
    dbg_valid = 1'b1; dbg_writeb = 4'b0000; dbg_addr = 11'h077;
    for (int i = 0; i < 4; i++) cyc();
    dbg_valid = 1'b0;
    #4;
    checks++;
    if ({mem_read, mem_writeb, pl_stall} !== 6'b000001) begin
      errors++;
      $display("FAIL withdraw_force got rd=%b wb=%b st=%b exp 0 0000 1",
               mem_read, mem_writeb, pl_stall);
    end
    cyc();
    #4;
    checks++;
    if ({pl_stall, mem_read, dbg_rvalid, mem_addr} !== {3'b010, 11'h040}) begin
      errors++;
      $display("FAIL withdraw_resume got st=%b rd=%b dv=%b addr=%h exp 0 1 0 040",
               pl_stall, mem_read, dbg_rvalid, mem_addr);
    end
    pl_read = 1'b0;
    cyc();
  endtask

  task automatic test_back_to_back();
    dbg_valid = 1'b1; dbg_writeb = 4'b0000; dbg_addr = 11'h100;
    #4;
    checks++;
    if ({dbg_ready, mem_read, mem_addr} !== {2'b11, 11'h100}) begin
      errors++;
      $display("FAIL b2b_rd0 got rdy=%b rd=%b addr=%h exp 1 1 100", dbg_ready, mem_read, mem_addr);
    end
    cyc();
    dbg_writeb = 4'b1111; dbg_wdata = 32'h5A5A_5A5A; dbg_addr = 11'h101;
    mem_rdata = 32'h1111_2222;
    #4;
    checks++;
    if ({dbg_ready, mem_read, mem_writeb, mem_wdata, dbg_rvalid, dbg_rdata} !==
        {2'b10, 4'b1111, 32'h5A5A_5A5A, 1'b1, 32'h1111_2222}) begin
      errors++;
      $display("FAIL b2b_wr1 got rdy=%b rd=%b wb=%b wd=%h dv=%b d=%h exp 1 0 1111 5a5a5a5a 1 11112222",
               dbg_ready, mem_read, mem_writeb, mem_wdata, dbg_rvalid, dbg_rdata);
    end
    cyc();
    dbg_writeb = 4'b0000; dbg_addr = 11'h102;
    #4;
    checks++;
    if ({dbg_ready, mem_read, dbg_rvalid} !== 3'b110) begin
      errors++;
      $display("FAIL b2b_rd2 got rdy=%b rd=%b dv=%b exp 1 1 0", dbg_ready, mem_read, dbg_rvalid);
    end
    cyc();
    dbg_valid = 1'b0; mem_rdata = 32'h3333_4444;
    #4;
    checks++;
    if ({dbg_rvalid, dbg_rdata} !== {1'b1, 32'h3333_4444}) begin
      errors++;
      $display("FAIL b2b_resp got dv=%b d=%h exp 1 33334444", dbg_rvalid, dbg_rdata);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    dbg_valid = 1'b1; dbg_writeb = 4'b0000; dbg_addr = 11'h077;
    #4;
    checks++;
    if (dbg_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_grant got rdy=%b exp 1", dbg_ready);
    end
    cyc();
    rst = 1'b1; pl_read = 1'b1; pl_addr = 11'h050;
    #4;
    checks++;
    if (dbg_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_rvalid got dv=%b exp 0", dbg_rvalid);
    end
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #4;
      checks++;
      if ({dbg_ready, dbg_rvalid} !== 2'b00) begin
        errors++;
        $display("FAIL rstmid_refuse cyc %0d got rdy=%b dv=%b exp 0 0", i, dbg_ready, dbg_rvalid);
      end
      cyc();
    end
    #4;
    checks++;
    if ({dbg_ready, pl_stall} !== 2'b11) begin
      errors++;
      $display("FAIL rstmid_force got rdy=%b st=%b exp 1 1", dbg_ready, pl_stall);
    end
    cyc();
    dbg_valid = 1'b0; pl_read = 1'b0;
    cyc();
  endtask

  initial begin
    rst = 1'b1;
    pl_read = 1'b0; pl_writeb = 4'b0000; pl_addr = '0; pl_wdata = 32'h0;
    dbg_valid = 1'b0; dbg_writeb = 4'b0000; dbg_addr = '0; dbg_wdata = 32'h0;
    mem_rdata = 32'h0;
    test_reset();
    test_pl_read();
    test_starvation();
    test_force_write();
    test_withdraw();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
